// File: rtl/conv_pkg.sv
// Shared definitions for the convolution compute stage: FSM encoding and
// elaboration-time sizing helpers.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MUL   = 3'd3,
    ST_SUM   = 3'd4,
    ST_STORE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int out_dim(input int data_dim, input int kernel);
    return data_dim - kernel + 1;
  endfunction

endpackage

// File: rtl/mac_tree.sv
// Two-stage signed dot product: registered products, then a registered
// adder tree sign-extended to the accumulator width.
module mac_tree #(
  parameter int kernel_size = 2,
  parameter int point_width = 8,
  parameter int acc_width   = 20
) (
  input  logic                                             i_clock,
  input  logic                                             i_reset,
  input  logic                                             i_en,
  input  logic [point_width*kernel_size*kernel_size-1:0]   i_window,
  input  logic [point_width*kernel_size*kernel_size-1:0]   i_filter,
  output logic [acc_width-1:0]                             o_sum
);

  localparam int NPTS   = kernel_size * kernel_size;
  localparam int PROD_W = 2 * point_width;

  logic signed [PROD_W-1:0]    r_prod [NPTS];
  logic signed [acc_width-1:0] w_sum;
  logic        [acc_width-1:0] r_sum;

  // Products are captured only in the MUL step so they stay stable for SUM.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int i = 0; i < NPTS; i++) r_prod[i] <= '0;
    end else if (i_en) begin
      for (int i = 0; i < NPTS; i++)
        r_prod[i] <= PROD_W'($signed(i_window[i*point_width +: point_width])) *
                     PROD_W'($signed(i_filter[i*point_width +: point_width]));
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NPTS; i++) w_sum = w_sum + acc_width'(r_prod[i]);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) r_sum <= '0;
    else          r_sum <= w_sum;
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/window_mac.sv
// Convolution compute stage: pulls windows from the window generator, computes
// one signed dot product per window and assembles the output feature map.
module window_mac
  import conv_pkg::*;
#(
  parameter int kernel_size = 2,
  parameter int data_width  = 4,
  parameter int data_height = 4,
  parameter int point_width = 8,
  parameter int acc_width   = 20
) (
  input  logic                                            i_clock,
  input  logic                                            i_reset,
  input  logic                                            i_start,
  output logic                                            o_en_read,
  output logic                                            o_slide,
  input  logic                                            i_window_rdy,
  input  logic                                            i_window_gen_end,
  input  logic [point_width*kernel_size*kernel_size-1:0]  i_window,
  input  logic [point_width*kernel_size*kernel_size-1:0]  i_filter,
  output logic [acc_width*out_dim(data_width, kernel_size)*out_dim(data_height, kernel_size)-1:0] o_ofmap,
  output logic                                            o_ofmap_valid,
  output logic                                            o_busy,
  output logic                                            o_proto_err
);

  localparam int OUT_N = out_dim(data_width, kernel_size) * out_dim(data_height, kernel_size);
  localparam int IDX_W = (clog2(OUT_N) < 1) ? 1 : clog2(OUT_N);
  localparam int WIN_W = point_width * kernel_size * kernel_size;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_N - 1);
  localparam logic [IDX_W-1:0] ERR_IDX  = IDX_W'(OUT_N - 2);

  state_t                   r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [WIN_W-1:0]         r_window;
  logic [WIN_W-1:0]         r_filter;
  logic [acc_width*OUT_N-1:0] r_ofmap;
  logic                     r_en_read;
  logic                     r_slide;
  logic                     r_ofmap_valid;
  logic                     r_busy;
  logic                     r_proto_err;
  logic                     w_mul_en;
  logic [acc_width-1:0]     w_sum;

  assign w_mul_en = (r_state == ST_MUL);

  mac_tree #(
    .kernel_size (kernel_size),
    .point_width (point_width),
    .acc_width   (acc_width)
  ) u_mac_tree (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_en     (w_mul_en),
    .i_window (r_window),
    .i_filter (r_filter),
    .o_sum    (w_sum)
  );

  // Frame sequencer; all handshake and status outputs are registered here.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_window      <= '0;
      r_filter      <= '0;
      r_ofmap       <= '0;
      r_en_read     <= 1'b0;
      r_slide       <= 1'b0;
      r_ofmap_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_en_read <= 1'b0;
      r_slide   <= 1'b0;
      // An end flag while more than one window is still outstanding is a protocol error.
      if (r_state == ST_WAIT && i_window_gen_end && r_idx < ERR_IDX)
        r_proto_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_en_read <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (i_window_rdy) begin
            r_window <= i_window;
            r_filter <= i_filter;
            r_state  <= ST_MUL;
          end
        end
        ST_MUL: r_state <= ST_SUM;
        ST_SUM: r_state <= ST_STORE;
        ST_STORE: begin
          r_ofmap[int'(r_idx)*acc_width +: acc_width] <= w_sum;
          if (r_idx == LAST_IDX) begin
            r_ofmap_valid <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_DONE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_slide <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_DONE: begin
          if (i_start) begin
            r_ofmap_valid <= 1'b0;
            r_idx         <= '0;
            r_en_read     <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_LOAD;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_en_read     = r_en_read;
  assign o_slide       = r_slide;
  assign o_ofmap       = r_ofmap;
  assign o_ofmap_valid = r_ofmap_valid;
  assign o_busy        = r_busy;
  assign o_proto_err   = r_proto_err;

endmodule
